// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder result accumulator: FSM state type and
// the fixed widths of the incoming operand and the sample counter.
package adder_acc_pkg;

  // Operand is {cout, s} from the 4-bit full adder.
  localparam int OPND_W = 5;

  // Sample counter width; wide enough for any batch length up to 255.
  localparam int CNT_W = 8;

  // ACCUM: collecting results; DONE: presenting the batch total to the sink.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage : adder_acc_pkg

// File: rtl/acc_sat_add.sv
// Combinational ACC_W+1-bit add of the running total and a 5-bit operand,
// with carry-out overflow detect.
// Optional feature macro: ADDER_ACC_SATURATE_EN (clamp to all-ones on overflow
// instead of wrapping).
module acc_sat_add
  import adder_acc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [OPND_W-1:0] i_opnd,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic [ACC_W:0] w_full;

  // One extra bit so the carry out of the accumulator width is observable.
  assign w_full = {1'b0, i_acc} + {{(ACC_W + 1 - OPND_W){1'b0}}, i_opnd};
  assign o_ovf  = w_full[ACC_W];

`ifdef ADDER_ACC_SATURATE_EN
  // Once clamped, any further add carries out again, so the total stays pinned.
  assign o_sum = o_ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  // Keep the low bits only: the total wraps modulo 2^ACC_W.
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule : acc_sat_add

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT adder results {cout, s} received over a valid/ready
// handshake, then presents the batch total with a sticky overflow flag until
// the sink takes it.
// Optional feature macro: ADDER_ACC_SATURATE_EN (saturating accumulate,
// implemented in acc_sat_add).
module adder_sum_accumulator
  import adder_acc_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int COUNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] sample_cnt
);

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic             w_accept;
  logic             w_handshake;
  logic             w_last;

  // Adder datapath: running total plus the current operand.
  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_acc  (r_acc),
    .i_opnd ({cout, s}),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // The accept that closes the batch is the one seen with COUNT-1 results held.
  assign w_last      = (r_cnt == CNT_W'(COUNT - 1));
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = out_valid && out_ready;

  // State register; reset always lands in ACCUM with the batch discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs, decoded from the registered state only.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ACCUM;
        end
      end
      default: begin
        w_state_next = ACCUM;
      end
    endcase
  end

  // Accumulator, sample counter and sticky overflow; cleared when the sink
  // takes the total so the next batch starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
    end else if (w_handshake) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign acc_out    = r_acc;
  assign overflow   = r_ovf;
  assign sample_cnt = r_cnt;

endmodule : adder_sum_accumulator

// File: tb/tb_adder_sum_accumulator.sv
// Self-checking bench for adder_sum_accumulator (ACC_W=8, COUNT=16).
// Honours ADDER_ACC_SATURATE_EN when the design is built with it.
module tb_adder_sum_accumulator;

  localparam int ACC_W = 8;
  localparam int COUNT = 16;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       s = 4'd0;
  logic             cout = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             overflow;
  logic [7:0]       sample_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(
    .ACC_W (ACC_W),
    .COUNT (COUNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s          (s),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .overflow   (overflow),
    .sample_cnt (sample_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Batch-level view: a running integer total, how many results were taken,
  // and whether the total is waiting for the sink.
  int m_total = 0;
  int m_taken = 0;
  bit m_ovf = 0;
  bit m_waiting = 0;
  bit m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_total = 0; m_taken = 0; m_ovf = 0; m_waiting = 0; m_ok = 1;
    end else if (m_waiting) begin
      if (out_ready) begin
        m_total = 0; m_taken = 0; m_ovf = 0; m_waiting = 0;
      end
    end else if (in_valid) begin
      m_total = m_total + int'({cout, s});
      if (m_total > ACC_MAX) begin
        m_ovf = 1;
`ifdef ADDER_ACC_SATURATE_EN
        m_total = ACC_MAX;
`else
        m_total = m_total - (ACC_MAX + 1);
`endif
      end
      m_taken = m_taken + 1;
      if (m_taken == COUNT) m_waiting = 1;
    end
  end

  // Totals delivered to the sink, captured at the handshake.
  int got_tot[$];
  int got_ovf[$];

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready", int'(in_ready), int'(!m_waiting));
      chk("out_valid", int'(out_valid), int'(m_waiting));
      chk("acc_out", int'(acc_out), m_total);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("sample_cnt", int'(sample_cnt), m_taken);
      if (out_valid && out_ready) begin
        got_tot.push_back(int'(acc_out));
        got_ovf.push_back(int'(overflow));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op);
    logic [4:0] v;
    v = 5'(op);
    cout = v[4];
    s = v[3:0];
  endtask

  int idle;
  int exp_ovf_tot;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    $display("reset released: in_ready=%0b out_valid=%0b", in_ready, out_valid);

    // 1. Basic batch of operand 1, sink always ready
    out_ready = 1'b1;
    set_op(1);
    for (int i = 0; i < COUNT; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("s1_out_valid", int'(out_valid), 1);
    chk("s1_acc", int'(acc_out), 16);
    chk("s1_ovf", int'(overflow), 0);
    $display("batch1 total=%0d ovf=%0b", acc_out, overflow);
    step();
    chk("s1_valid_drop", int'(out_valid), 0);
    chk("s1_acc_clear", int'(acc_out), 0);

    // 2. Overflow with operand 31, sink holds off
    out_ready = 1'b0;
    set_op(31);
    for (int i = 0; i < COUNT; i++) begin
      in_valid = 1'b1;
      step();
    end
`ifdef ADDER_ACC_SATURATE_EN
    exp_ovf_tot = 255;
`else
    exp_ovf_tot = 240;
`endif
    chk("s2_acc", int'(acc_out), exp_ovf_tot);
    chk("s2_ovf", int'(overflow), 1);
    $display("batch2 total=%0d ovf=%0b", acc_out, overflow);

    // 3. Backpressure: 5 cycles in DONE with in_valid still asserted
    set_op(5);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      step();
      chk("s3_out_valid", int'(out_valid), 1);
      chk("s3_in_ready", int'(in_ready), 0);
      chk("s3_acc", int'(acc_out), exp_ovf_tot);
      chk("s3_ovf", int'(overflow), 1);
      chk("s3_cnt", int'(sample_cnt), 16);
      $display("hold cycle %0d total=%0d cnt=%0d", i, acc_out, sample_cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("s3_release_acc", int'(acc_out), 0);
    chk("s3_release_ovf", int'(overflow), 0);
    chk("s3_release_ready", int'(in_ready), 1);

    // 4. Sparse input: operand 3, in_valid low on alternate cycles
    out_ready = 1'b0;
    set_op(3);
    for (int i = 0; i < COUNT; i++) begin
      if (i == COUNT - 1) chk("s4_not_early", int'(out_valid), 0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (i < COUNT - 1) step();
    end
    chk("s4_out_valid", int'(out_valid), 1);
    chk("s4_acc", int'(acc_out), 48);
    $display("batch4 total=%0d", acc_out);
    out_ready = 1'b1;
    step();

    // 5. Mid-batch reset after 7 accepts of operand 10
    out_ready = 1'b0;
    set_op(10);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("s5_partial_acc", int'(acc_out), 70);
    chk("s5_partial_cnt", int'(sample_cnt), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_rst_acc", int'(acc_out), 0);
    chk("s5_rst_cnt", int'(sample_cnt), 0);
    chk("s5_rst_ready", int'(in_ready), 1);
    set_op(1);
    for (int i = 0; i < COUNT; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("s5_batch_acc", int'(acc_out), 16);
    $display("batch5 total=%0d", acc_out);
    out_ready = 1'b1;
    step();

    // 6. Back-to-back batches, operands 2, 3, 4
    got_tot.delete();
    got_ovf.delete();
    idle = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3 * (COUNT + 1); i++) begin
      set_op(2 + i / (COUNT + 1));
      in_valid = 1'b1;
      if (!in_ready) idle++;
      step();
    end
    in_valid = 1'b0;
    chk("s6_idle_cycles", idle, 3);
    chk("s6_batches", got_tot.size(), 3);
    for (int b = 0; b < 3; b++) begin
      if (b < got_tot.size()) begin
        chk("s6_total", got_tot[b], 16 * (b + 2));
        chk("s6_ovf", got_ovf[b], 0);
        $display("b2b batch %0d total=%0d", b, got_tot[b]);
      end
    end
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_adder_sum_accumulator

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Downstream consumer of the 4-bit full adder. Accepts each 5-bit adder result `{cout, s}` through a valid/ready handshake and accumulates COUNT results into a wider register. When the batch is complete it presents the total with a sticky overflow flag. It then holds the total until the sink accepts it.

## Interface
Parameters:
- ACC_W, 8, accumulator width in bits; legal range 6 to 16.
- COUNT, 16, number of adder results per batch; legal range 2 to 255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  an adder result is present on s/cout.
- in_ready  output  1  block can accept a result this cycle.
- s  input  4  adder sum bits.
- cout  input  1  adder carry-out.
- out_valid  output  1  acc_out holds a completed batch total.
- out_ready  input  1  sink accepts the total this cycle.
- acc_out  output  ACC_W  running or final accumulated total.
- overflow  output  1  sticky flag: the accumulator exceeded 2^ACC_W − 1 during this batch.
- sample_cnt  output  8  number of results accepted in the current batch.

## Operation
- Each operand is `{cout, s}`, a 5-bit unsigned value (0 to 31) zero-extended to ACC_W+1 bits.
- The FSM has two states: ACCUM and DONE.
- **ACCUM**
  - in_ready=1 and out_valid=0.
  - An input is accepted when in_valid && in_ready.
  - On accept: acc ← acc + operand, and sample_cnt ← sample_cnt + 1.
  - If bit ACC_W of the sum is 1, overflow is set and stays set.
  - An accept when sample_cnt == COUNT−1 moves the FSM to DONE.
  - in_valid=0 leaves all state unchanged.
- **DONE**
  - in_ready=0 and out_valid=1.
  - acc_out, overflow and sample_cnt (== COUNT) are held stable.
  - A handshake (out_valid && out_ready) clears acc, sample_cnt and overflow to 0 and returns the FSM to ACCUM.
- Arithmetic is performed at ACC_W+1 bits. The stored value is the low ACC_W bits, so the default build wraps.
- Reset at any point, including mid-batch or during DONE:
  - the FSM goes to ACCUM;
  - acc_out, sample_cnt and overflow clear to 0;
  - the partial batch is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, acc_out=0, overflow=0, sample_cnt=0.
- in_ready and out_valid are decoded from the registered state only. They have no combinational path from in_valid or out_ready.
- acc_out and sample_cnt reflect an accepted input one cycle after the accept edge.
- out_valid rises on the cycle after the COUNT-th accept.
- DONE lasts at least 1 cycle. Peak throughput is therefore COUNT results per COUNT+1 cycles.
- While in DONE, in_valid is ignored. The upstream source must hold its data until in_ready returns.
- A handshake in DONE and a new accept cannot occur in the same cycle. The first accept of the next batch is possible the cycle after out_ready.
- rst takes precedence over every handshake in the same cycle.

## Configuration
- Macro: `ADDER_ACC_SATURATE_EN`.
- Defined: on overflow, acc clamps to 2^ACC_W − 1 and stays clamped for the rest of the batch. overflow is set as in the default build.
- Undefined: acc wraps modulo 2^ACC_W, and overflow is set as above.

## Structure
- Shared package `adder_acc_pkg` contains:
  - the state enum (ACCUM, DONE);
  - localparam OPND_W = 5;
  - localparam CNT_W = 8.
- Sub-module `acc_sat_add` is a combinational ACC_W+1-bit add with overflow detect. It contains the optional saturation under the macro.
- The top module holds the FSM, counters and registers.

## Test plan
All scenarios use ACC_W=8 and COUNT=16.

1. **Basic batch:** 16 back-to-back accepts of {cout=0, s=0001}, out_ready=1 → acc_out=16, overflow=0, out_valid for 1 cycle, then acc_out=0.
2. **Overflow:** 16 accepts of {cout=1, s=1111}, operand 31 →
   - default build: acc_out=240 (496 mod 256), overflow=1;
   - with ADDER_ACC_SATURATE_EN: acc_out=255, overflow=1.
3. **Sink backpressure:** out_ready held low for 5 cycles after DONE is entered →
   - out_valid, acc_out and overflow are stable for all 5 cycles;
   - in_ready=0 throughout;
   - in_valid asserted during DONE does not change acc_out or sample_cnt.
4. **Sparse input:** 16 accepts of operand 3, with in_valid low on alternate cycles → acc_out=48, and out_valid rises exactly one cycle after the 16th accept.
5. **Mid-batch reset:** 7 accepts of operand 10, then rst for 1 cycle → acc_out=0, sample_cnt=0, in_ready=1. The next full batch of operand 1 gives acc_out=16.
6. **Back-to-back batches:** continuous in_valid and out_ready held high → each batch total is correct, and exactly one idle input cycle (in_ready=0) occurs per batch.
